// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
// master drives the controls and observes the status; slave is the timer side.
interface down_counter_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load, load_val, start, stop, auto_reload,
    input  count, busy, tc, done
  );

  modport slave (
    input  load, load_val, start, stop, auto_reload,
    output count, busy, tc, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a loaded value to zero, pulses tc,
// then either stops (sticky done) or auto-reloads and keeps running.
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  down_counter_timer_if.slave  bus
);

  localparam int unsigned CW = WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] reload_q, reload_d;
  logic          busy_q, busy_d;
  logic          tc_q, tc_d;
  logic          done_q, done_d;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  // Next state: load beats stop, stop beats start.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;

    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = ST_IDLE;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.stop && bus.start && (count_q != '0)) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_PAUSE;
          end else if (count_q > CW'(1)) begin
            count_d = count_q - CW'(1);
          end else if (count_q == CW'(1)) begin
            tc_d = 1'b1;
            if (bus.auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            // Unreachable guard: never decrement below zero.
            state_d = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          if (!bus.stop && bus.start) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the timer.
module tb_down_counter_timer;

  localparam int unsigned W = 4;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  down_counter_timer_if #(.WIDTH(W)) bus ();

  down_counter_timer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: 0 = idle, 1 = running, 2 = paused.
  int m_count;
  int m_reload;
  int m_mode;
  bit m_tc;
  bit m_done;

  task automatic model_reset();
    m_count  = 0;
    m_reload = 0;
    m_mode   = 0;
    m_tc     = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit st,
                            input bit sp, input bit ar);
    m_tc = 1'b0;
    if (ld) begin
      m_count  = lv;
      m_reload = lv;
      m_mode   = 0;
      m_done   = 1'b0;
    end else if (m_mode == 0) begin
      if (st && !sp && m_count != 0) begin
        m_mode = 1;
        m_done = 1'b0;
      end
    end else if (m_mode == 1) begin
      if (sp) m_mode = 2;
      else if (m_count > 1) m_count = m_count - 1;
      else begin
        m_tc = 1'b1;
        if (ar) m_count = m_reload;
        else begin
          m_count = 0;
          m_done  = 1'b1;
          m_mode  = 0;
        end
      end
    end else begin
      if (st && !sp) m_mode = 1;
    end
  endtask

  task automatic drive(input bit ld, input int lv, input bit st,
                       input bit sp, input bit ar);
    bus.load        = ld;
    bus.load_val    = W'(lv);
    bus.start       = st;
    bus.stop        = sp;
    bus.auto_reload = ar;
  endtask

  // One rising edge; the model sees the same sampled inputs, then settle.
  task automatic tick();
    @(posedge clk);
    model_step(bus.load, int'(bus.load_val), bus.start, bus.stop, bus.auto_reload);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #3;
    vectors++;
    if ({bus.count, bus.busy, bus.tc, bus.done} !== {W'(0), 3'b000}) begin
      miscompares++;
      $display("FAIL reset: got count=%0d busy=%0b tc=%0b done=%0b, want all 0",
               bus.count, bus.busy, bus.tc, bus.done);
    end
    #9 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_one_shot();
    int exp_c[6] = '{5, 4, 3, 2, 1, 0};
    drive(1, 5, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus.count !== W'(exp_c[i]) || bus.tc !== (i == 5) ||
          bus.busy !== (i < 5) || bus.done !== (i == 5)) begin
        miscompares++;
        $display("FAIL one_shot[%0d]: got count=%0d busy=%0b tc=%0b done=%0b, want count=%0d busy=%0b tc=%0b done=%0b",
                 i, bus.count, bus.busy, bus.tc, bus.done, exp_c[i], i < 5, i == 5, i == 5);
      end
      tick();
    end
    vectors++;
    if (bus.count !== W'(0) || bus.tc !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL one_shot_hold: got count=%0d tc=%0b done=%0b busy=%0b, want 0 0 1 0",
               bus.count, bus.tc, bus.done, bus.busy);
    end
  endtask

  task automatic test_auto_reload();
    drive(1, 3, 0, 0, 1); tick();
    drive(0, 0, 1, 0, 1); tick();
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      int ec = 3 - (i % 3);
      bit et = (i != 0) && (i % 3 == 0);
      vectors++;
      if (bus.count !== W'(ec) || bus.tc !== et || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL auto_reload[%0d]: got count=%0d tc=%0b busy=%0b done=%0b, want count=%0d tc=%0b busy=1 done=0",
                 i, bus.count, bus.tc, bus.busy, bus.done, ec, et);
      end
      tick();
    end
  endtask

  task automatic test_pause();
    drive(1, 12, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick(); tick(); tick();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.count !== W'(9) || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL pause_hold[%0d]: got count=%0d busy=%0b, want count=9 busy=1",
                 i, bus.count, bus.busy);
      end
    end
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    vectors++;
    if (bus.count !== W'(9) || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_resume_edge: got count=%0d busy=%0b, want count=9 busy=1", bus.count, bus.busy);
    end
    tick();
    vectors++;
    if (bus.count !== W'(8)) begin
      miscompares++;
      $display("FAIL pause_resume_dec: got count=%0d, want 8", bus.count);
    end
  endtask

  task automatic test_reload_midrun();
    drive(1, 6, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick(); tick();
    drive(1, 10, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    vectors++;
    if (bus.count !== W'(10) || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_midrun: got count=%0d busy=%0b tc=%0b, want count=10 busy=0 tc=0",
               bus.count, bus.busy, bus.tc);
    end
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick(); tick();
    drive(0, 0, 0, 0, 0);
    vectors++;
    if (bus.count !== W'(0) || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL start_at_zero: got count=%0d busy=%0b tc=%0b, want 0 0 0",
               bus.count, bus.busy, bus.tc);
    end
  endtask

  task automatic test_load_start_same();
    drive(1, 15, 1, 0, 0); tick();
    vectors++;
    if (bus.count !== W'(15) || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_vs_start: got count=%0d busy=%0b, want count=15 busy=0", bus.count, bus.busy);
    end
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      vectors++;
      if (bus.count !== W'(15 - k) || bus.tc !== (k == 15)) begin
        miscompares++;
        $display("FAIL full_range[%0d]: got count=%0d tc=%0b, want count=%0d tc=%0b",
                 k, bus.count, bus.tc, 15 - k, k == 15);
      end
    end
    tick();
    vectors++;
    if (bus.count !== W'(0) || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL no_wrap: got count=%0d busy=%0b done=%0b, want 0 0 1", bus.count, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_midrun();
    drive(1, 7, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick(); tick(); tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({bus.count, bus.busy, bus.tc, bus.done} !== {W'(0), 3'b000}) begin
      miscompares++;
      $display("FAIL reset_midrun: got count=%0d busy=%0b tc=%0b done=%0b, want all 0",
               bus.count, bus.busy, bus.tc, bus.done);
    end
    @(negedge clk) reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), int'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)));
      tick();
      vectors++;
      if (bus.count !== W'(m_count) || bus.busy !== (m_mode != 0) ||
          bus.tc !== m_tc || bus.done !== m_done) begin
        miscompares++;
        $display("FAIL random[%0d]: got count=%0d busy=%0b tc=%0b done=%0b, want count=%0d busy=%0b tc=%0b done=%0b",
                 i, bus.count, bus.busy, bus.tc, bus.done, m_count, m_mode != 0, m_tc, m_done);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_reset_midrun();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_reload_midrun();
    test_load_start_same();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
